// File: rtl/bk_pkg.sv
// Shared types and header constants for the backup-RAM save/load sequencer.
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WAIT,
    FMT
  } state_t;

  typedef enum logic {
    OP_LOAD,
    OP_SAVE
  } op_t;

  localparam int HDR_LEN = 4;

  // "HUBM" signature followed by version/geometry words
  localparam logic [15:0] HDR [HDR_LEN] = '{
    16'h5548, 16'h4D42, 16'h8800, 16'h8010
  };

  function automatic logic [15:0] hdr_word(input logic [7:0] a);
    if (a < 8'(HDR_LEN)) return HDR[a[1:0]];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/bk_edge.sv
// Rising-edge detector with registered previous value.
module bk_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev <= 1'b0;
    else          prev <= d;

  assign rise = d & ~prev;

endmodule

// File: rtl/bk_save_ctrl.sv
// Backup-RAM sector save/load/format sequencer for the HPS sector port.
// Optional autosave of the last-used slot: define BK_AUTOSAVE_EN.
module bk_save_ctrl
  import bk_pkg::*;
#(
  parameter int SLOT_W    = 2,
  parameter int SECT_W    = 4,
  parameter int HDR_WORDS = 4,
  parameter int TIMEOUT_W = 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              downloading,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic              img_size_nz,
  input  logic [SLOT_W-1:0] slot,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic              sd_ack,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic [7:0]        fmt_addr,
  output logic [15:0]       fmt_data,
  output logic              fmt_we,
  output logic              bk_ena,
  output logic              bk_busy,
  output logic              bk_loading,
  output logic              bk_err,
  input  logic              autosave_trig,
  input  logic              bram_dirty,
  output logic              dirty_clr
);

  state_t state, state_d;
  op_t    op, op_d, go_op;

  logic [SLOT_W-1:0]    slot_q, slot_d, go_slot, auto_slot;
  logic [SECT_W-1:0]    idx, idx_d;
  logic [TIMEOUT_W-1:0] tmo, tmo_d;
  logic [31:0]          lba_d;
  logic [7:0]           faddr_d;
  logic [15:0]          fdata_d;
  logic ld_rise, sv_rise, fm_rise, dl_rise, auto_go, go;
  logic ack_q, ack_rise, ack_fall, tmo_hit;
  logic rd_d, wr_d, busy_d, ld_d, err_d, ena_d, dclr_d, we_d;

  bk_edge u_ld (.clk(clk_sys), .reset_n(reset_n), .d(load_req),    .rise(ld_rise));
  bk_edge u_sv (.clk(clk_sys), .reset_n(reset_n), .d(save_req),    .rise(sv_rise));
  bk_edge u_fm (.clk(clk_sys), .reset_n(reset_n), .d(format_req),  .rise(fm_rise));
  bk_edge u_dl (.clk(clk_sys), .reset_n(reset_n), .d(downloading), .rise(dl_rise));

`ifdef BK_AUTOSAVE_EN
  logic au_rise;
  logic [SLOT_W-1:0] last_slot;

  bk_edge u_au (.clk(clk_sys), .reset_n(reset_n), .d(autosave_trig), .rise(au_rise));

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) last_slot <= '0;
    else if (go)  last_slot <= go_slot;

  assign auto_go   = au_rise & bram_dirty;
  assign auto_slot = last_slot;
`else
  logic unused_auto;
  assign unused_auto = autosave_trig ^ bram_dirty;
  assign auto_go     = 1'b0;
  assign auto_slot   = '0;
`endif

  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;
  assign tmo_hit  = &tmo;

  always_comb begin
    state_d = state;
    op_d    = op;
    slot_d  = slot_q;
    idx_d   = idx;
    lba_d   = sd_lba;
    rd_d    = sd_rd;
    wr_d    = sd_wr;
    busy_d  = bk_busy;
    ld_d    = bk_loading;
    err_d   = bk_err;
    dclr_d  = 1'b0;
    we_d    = 1'b0;
    faddr_d = fmt_addr;
    fdata_d = fmt_data;
    go      = 1'b0;
    go_op   = OP_LOAD;
    go_slot = slot;

    ena_d = bk_ena;
    if (dl_rise) ena_d = 1'b0;
    if (downloading && img_mounted && img_size_nz && !img_readonly)
      ena_d = 1'b1;

    if (dl_rise) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      busy_d  = 1'b0;
      ld_d    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_rise && bk_ena) begin
            go = 1'b1;
          end else if (sv_rise && bk_ena) begin
            go    = 1'b1;
            go_op = OP_SAVE;
          end else if (fm_rise) begin
            state_d = FMT;
            we_d    = 1'b1;
            faddr_d = 8'd0;
            fdata_d = hdr_word(8'd0);
            busy_d  = 1'b1;
            err_d   = 1'b0;
          end else if (auto_go && bk_ena) begin
            go      = 1'b1;
            go_op   = OP_SAVE;
            go_slot = auto_slot;
          end
          if (go) begin
            state_d = XFER;
            op_d    = go_op;
            slot_d  = go_slot;
            idx_d   = '0;
            lba_d   = 32'({go_slot, {SECT_W{1'b0}}});
            rd_d    = (go_op == OP_LOAD);
            wr_d    = (go_op == OP_SAVE);
            busy_d  = 1'b1;
            ld_d    = (go_op == OP_LOAD);
            err_d   = 1'b0;
          end
        end
        XFER, WAIT: begin
          if (tmo_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            busy_d  = 1'b0;
            ld_d    = 1'b0;
          end else if (state == XFER) begin
            if (ack_rise) begin
              rd_d    = 1'b0;
              wr_d    = 1'b0;
              state_d = WAIT;
            end
          end else if (ack_fall) begin
            if (&idx) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              ld_d    = 1'b0;
              dclr_d  = (op == OP_SAVE);
            end else begin
              idx_d   = idx + SECT_W'(1);
              lba_d   = 32'({slot_q, idx_d});
              rd_d    = (op == OP_LOAD);
              wr_d    = (op == OP_SAVE);
              state_d = XFER;
            end
          end
        end
        FMT: begin
          if (fmt_addr == 8'(HDR_WORDS - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            we_d    = 1'b1;
            faddr_d = fmt_addr + 8'd1;
            fdata_d = hdr_word(faddr_d);
          end
        end
      endcase
    end

    // Watchdog restarts on every state change, runs only while waiting on HPS
    if (state_d != state)                 tmo_d = '0;
    else if (state == XFER || state == WAIT) tmo_d = tmo + TIMEOUT_W'(1);
    else                                  tmo_d = '0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op         <= OP_LOAD;
      slot_q     <= '0;
      idx        <= '0;
      tmo        <= '0;
      ack_q      <= 1'b0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      fmt_addr   <= '0;
      fmt_data   <= '0;
      fmt_we     <= 1'b0;
      bk_ena     <= 1'b0;
      bk_busy    <= 1'b0;
      bk_loading <= 1'b0;
      bk_err     <= 1'b0;
      dirty_clr  <= 1'b0;
    end else begin
      state      <= state_d;
      op         <= op_d;
      slot_q     <= slot_d;
      idx        <= idx_d;
      tmo        <= tmo_d;
      ack_q      <= sd_ack;
      sd_lba     <= lba_d;
      sd_rd      <= rd_d;
      sd_wr      <= wr_d;
      fmt_addr   <= faddr_d;
      fmt_data   <= fdata_d;
      fmt_we     <= we_d;
      bk_ena     <= ena_d;
      bk_busy    <= busy_d;
      bk_loading <= ld_d;
      bk_err     <= err_d;
      dirty_clr  <= dclr_d;
    end
  end

endmodule

// File: tb/tb_bk_save_ctrl.sv
// Directed + randomized bench for bk_save_ctrl with an HPS sector responder.
module tb_bk_save_ctrl;

  localparam int SLOT_W    = 2;
  localparam int SECT_W    = 4;
  localparam int HDR_WORDS = 4;
  localparam int TIMEOUT_W = 8;
  localparam int NSECT     = 1 << SECT_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic downloading = 1'b0;
  logic img_mounted = 1'b0;
  logic img_readonly = 1'b0;
  logic img_size_nz = 1'b0;
  logic [SLOT_W-1:0] slot = '0;
  logic load_req = 1'b0;
  logic save_req = 1'b0;
  logic format_req = 1'b0;
  logic sd_ack = 1'b0;
  logic autosave_trig = 1'b0;
  logic bram_dirty = 1'b0;
  logic [31:0] sd_lba;
  logic sd_rd, sd_wr, fmt_we, bk_ena, bk_busy;
  logic bk_loading, bk_err, dirty_clr;
  logic [7:0]  fmt_addr;
  logic [15:0] fmt_data;

  logic [15:0] hdr_exp [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bk_save_ctrl #(
    .SLOT_W(SLOT_W), .SECT_W(SECT_W),
    .HDR_WORDS(HDR_WORDS), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n),
    .downloading(downloading), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size_nz(img_size_nz),
    .slot(slot), .load_req(load_req), .save_req(save_req),
    .format_req(format_req), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .fmt_addr(fmt_addr), .fmt_data(fmt_data), .fmt_we(fmt_we),
    .bk_ena(bk_ena), .bk_busy(bk_busy), .bk_loading(bk_loading),
    .bk_err(bk_err), .autosave_trig(autosave_trig),
    .bram_dirty(bram_dirty), .dirty_clr(dirty_clr)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input bit rd, input int sl);
    slot = SLOT_W'(sl);
    if (rd) load_req = 1'b1;
    else    save_req = 1'b1;
    tick(1);
    chk("start_rd", 32'(sd_rd), 32'(rd));
    chk("start_wr", 32'(sd_wr), 32'(!rd));
    chk("start_busy", 32'(bk_busy), 1);
    chk("start_loading", 32'(bk_loading), 32'(rd));
    chk("start_err", 32'(bk_err), 0);
    load_req = 1'b0;
    save_req = 1'b0;
  endtask

  // Plays the HPS side; expected LBA is slot*NSECT + sector, in order.
  task automatic serve(input bit rd, input int sl, input bit poke,
                       input int stop_at);
    for (int k = 0; k < NSECT; k++) begin
      int w;
      w = 0;
      while ((rd ? sd_rd : sd_wr) !== 1'b1 && w < 20) begin
        tick(1);
        w++;
      end
      chk("strobe_latency", 32'(w), 0);
      chk("lba", sd_lba, 32'(sl * NSECT + k));
      chk("other_strobe", 32'(rd ? sd_wr : sd_rd), 0);
      chk("busy", 32'(bk_busy), 1);
      chk("loading", 32'(bk_loading), 32'(rd));
      if (k == stop_at) return;
      tick($urandom_range(0, 3));
      sd_ack = 1'b1;
      if (poke && k == 3) save_req = 1'b1;
      tick(1);
      chk("ack_clears_strobe", 32'(rd ? sd_rd : sd_wr), 0);
      tick($urandom_range(0, 3));
      sd_ack = 1'b0;
      tick(1);
      if (k == NSECT - 1) begin
        chk("done_busy", 32'(bk_busy), 0);
        chk("done_loading", 32'(bk_loading), 0);
        chk("dirty_clr", 32'(dirty_clr), 32'(!rd));
        tick(1);
        chk("dirty_clr_pulse", 32'(dirty_clr), 0);
        chk("idle_rd", 32'(sd_rd), 0);
        chk("idle_wr", 32'(sd_wr), 0);
      end
    end
    if (poke) save_req = 1'b0;
  endtask

  initial begin
    int n;
    int sl;
    bit rd;

    tick(2);
    chk("rst_rd", 32'(sd_rd), 0);
    chk("rst_wr", 32'(sd_wr), 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_busy", 32'(bk_busy), 0);
    chk("rst_ena", 32'(bk_ena), 0);
    chk("rst_we", 32'(fmt_we), 0);
    reset_n = 1'b1;
    tick(1);
    chk("post_rst_busy", 32'(bk_busy), 0);
    chk("post_rst_err", 32'(bk_err), 0);

    save_req = 1'b1;
    tick(2);
    chk("save_without_ena", 32'(sd_wr), 0);
    save_req = 1'b0;

    downloading = 1'b1;
    tick(1);
    img_mounted = 1'b1;
    img_size_nz = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    downloading = 1'b0;
    tick(1);
    chk("mount_ena", 32'(bk_ena), 1);

    start(0, 2);
    serve(0, 2, 0, -1);

    start(1, 1);
    serve(1, 1, 1, -1);
    tick(2);
    chk("midload_save_dropped", 32'(sd_wr), 0);

    sl = $urandom_range(0, 3);
    slot = SLOT_W'(sl);
    load_req = 1'b1;
    save_req = 1'b1;
    tick(1);
    chk("prio_rd", 32'(sd_rd), 1);
    chk("prio_wr", 32'(sd_wr), 0);
    load_req = 1'b0;
    save_req = 1'b0;
    serve(1, sl, 0, -1);

    format_req = 1'b1;
    tick(1);
    for (int i = 0; i < HDR_WORDS; i++) begin
      chk("fmt_we", 32'(fmt_we), 1);
      chk("fmt_addr", 32'(fmt_addr), 32'(i));
      chk("fmt_data", 32'(fmt_data), 32'(hdr_exp[i]));
      chk("fmt_busy", 32'(bk_busy), 1);
      tick(1);
    end
    chk("fmt_end_we", 32'(fmt_we), 0);
    chk("fmt_end_busy", 32'(bk_busy), 0);
    format_req = 1'b0;

    for (int r = 0; r < 3; r++) begin
      rd = 1'($urandom_range(0, 1));
      sl = $urandom_range(0, 3);
      tick($urandom_range(1, 4));
      start(rd, sl);
      serve(rd, sl, 0, -1);
    end

    start(0, 3);
    n = 0;
    while (bk_err !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk("tmo_cycles", 32'(n >= 255 && n <= 256), 1);
    chk("tmo_wr", 32'(sd_wr), 0);
    chk("tmo_busy", 32'(bk_busy), 0);
    sl = $urandom_range(0, 3);
    tick(2);
    start(0, sl);
    serve(0, sl, 0, -1);

    sl = $urandom_range(0, 3);
    start(0, sl);
    serve(0, sl, 0, 5);
    tick(1);
    sd_ack = 1'b1;
    tick(1);
    downloading = 1'b1;
    tick(1);
    chk("abort_wr", 32'(sd_wr), 0);
    chk("abort_rd", 32'(sd_rd), 0);
    chk("abort_busy", 32'(bk_busy), 0);
    chk("abort_loading", 32'(bk_loading), 0);
    chk("abort_ena", 32'(bk_ena), 0);
    sd_ack = 1'b0;
    tick(2);
    save_req = 1'b1;
    tick(3);
    chk("post_abort_save_wr", 32'(sd_wr), 0);
    chk("post_abort_save_busy", 32'(bk_busy), 0);
    save_req = 1'b0;
    downloading = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_save_ctrl.md
Name: bk_save_ctrl

Overview:
- Parametrised backup-RAM save/load sequencer between the HPS sector interface (sd_lba/sd_rd/sd_wr/sd_ack) and the core's dual-port backup RAM.
- Generalises the per-core fixed 4-slot/16-sector logic: configurable slots and sectors per slot, a format sequencer, ack timeout with error flag, and abort on new ROM download.
- Sits in the emu top beside hps_io; drives core reset hold during loads.

Parameters:
- SLOT_W, 2, slot-select width; slot count = 2**SLOT_W.
- SECT_W, 4, sectors per slot = 2**SECT_W.
- HDR_WORDS, 4, number of 16-bit header words written by format.
- TIMEOUT_W, 24, ack-timeout counter width; timeout at all-ones.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- downloading  in  1  ROM download in progress (ioctl_download)
- img_mounted  in  1  save image mount strobe
- img_readonly  in  1  mounted image is read-only
- img_size_nz  in  1  mounted image size nonzero
- slot  in  SLOT_W  selected save slot (sampled at request)
- load_req  in  1  level; rising edge starts load
- save_req  in  1  level; rising edge starts save
- format_req  in  1  level; rising edge starts header format
- sd_ack  in  1  HPS sector acknowledge
- sd_lba  out  32  sector address
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- fmt_addr  out  8  header word address
- fmt_data  out  16  header word data
- fmt_we  out  1  header word write strobe
- bk_ena  out  1  save image usable
- bk_busy  out  1  transfer/format active (LED)
- bk_loading  out  1  hold core in reset
- bk_err  out  1  sticky ack-timeout flag
- autosave_trig  in  1  autosave request (used only with macro)
- bram_dirty  in  1  core wrote backup RAM since last save (used only with macro)
- dirty_clr  out  1  one-cycle pulse on successful save completion

Behaviour:
- Reset: all outputs 0; state IDLE; edge-detect registers 0.
- bk_ena: cleared on rising downloading. Set on any cycle where downloading & img_mounted & img_size_nz & ~img_readonly.
- Edge detect: registered previous value of each request input. Edges arriving while not IDLE are dropped.
- Simultaneous edges in IDLE: priority is load, then save, then format.
- States:
  - IDLE: on load/save edge with bk_ena=1, capture slot, idx=0, sd_lba={slot,idx} zero-extended, assert sd_rd (load) or sd_wr (save), bk_busy=1, bk_loading=load, go to XFER. Edges with bk_ena=0 are ignored.
  - XFER: on rising sd_ack, clear sd_rd/sd_wr and go to WAIT.
  - WAIT: on falling sd_ack, if idx all-ones go to IDLE, clear bk_busy/bk_loading, and pulse dirty_clr if the operation was a save. Otherwise idx+1, update sd_lba, re-assert sd_rd/sd_wr, and return to XFER.
  - FMT: entered from IDLE on format edge, with or without bk_ena. One word per cycle for HDR_WORDS cycles: fmt_we=1, fmt_addr=0..HDR_WORDS-1, fmt_data=header constant. Then go to IDLE. bk_busy=1 throughout. Back-to-back FMT writes take exactly HDR_WORDS cycles.
- Timeout: counter clears on each state entry and increments in XFER/WAIT. At all-ones: set bk_err, clear rd/wr/busy/loading, go to IDLE. bk_err clears on the next accepted request.
- Abort: rising downloading in any state forces IDLE and clears sd_rd, sd_wr, bk_busy, bk_loading. An in-flight sd_ack is ignored until it falls.
- Sector-boundary wrap: idx never exceeds 2**SECT_W-1. sd_lba upper bits are always zero.

Optional Feature:
- BK_AUTOSAVE_EN defined: a rising autosave_trig while IDLE & bk_ena & bram_dirty starts a save of the last-used slot. Autosave has lowest priority.
- Undefined: autosave_trig and bram_dirty are ignored, and dirty_clr still pulses on manual save completion.

Decomposition:
- Package bk_pkg: state enum (IDLE, XFER, WAIT, FMT), op enum (OP_LOAD, OP_SAVE), header constant array (HUBM signature 16'h5548, 16'h4D42, 16'h8800, 16'h8010).
- One sub-module bk_edge (rising-edge detector, reset_n async) instantiated per request input.

Test Plan:
- Mount writable image during download, then save_req with slot=2 (SECT_W=4) -> sd_wr for LBA 32..47 in order; bk_busy high throughout; dirty_clr pulses once after the 16th ack falls.
- load_req with slot=1 -> sd_rd for LBA 16..31; bk_loading high from request cycle to final ack fall; save_req mid-load is ignored.
- load_req and save_req rising on the same cycle -> load performed (sd_rd=1, sd_wr=0).
- format_req -> fmt_we on 4 consecutive cycles, addr 0..3, data 5548/4D42/8800/8010; then IDLE.
- Withhold sd_ack (TIMEOUT_W=8) -> after 255 cycles bk_err=1, sd_wr=0, IDLE; the next save clears bk_err.
- Assert downloading during sector 5 of a save -> next cycle IDLE, all strobes 0, bk_ena=0; a subsequent save_req is ignored.
